mc_control_fsm: RTL and testbench

- Multi-cycle control unit sequencing the 16-bit datapath: PC register, instruction register, ALU, register file, unified memory.
- Decodes the 4-bit opcode (IR[15:12]) and walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Drives `pcsignal` (PC load enable) plus all datapath mux selects and enables; stalls on memory via `mem_ready`.

---
 rtl/mc_control_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit datapath: fetch/decode/execute/memory/writeback sequencing.
// Define ILLEGAL_TRAP_EN to route opcodes 9-E through a TRAP state that vectors the PC to TRAP_VECTOR.
module mc_control_fsm #(
    parameter int unsigned     PC_W        = 16,
    parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'(16'h0002)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pcsignal,
    output logic [1:0]      pc_src,
    output logic [PC_W-1:0] trap_vec,
    output logic            ir_load,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_op,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            halted,
    output logic            illegal,
    output logic [3:0]      state_o
);

    typedef enum logic [3:0] {
        StInit    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StExecR   = 4'd3,
        StExecI   = 4'd4,
        StWbRi    = 4'd5,
        StMemAddr = 4'd6,
        StMemRd   = 4'd7,
        StWbMem   = 4'd8,
        StMemWr   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StHalt    = 4'd12,
        StTrap    = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_pc_load;
    logic [1:0] r_pc_src;
    logic       r_iord;
    logic       r_mem_read;
    logic       r_mem_write;
    logic       r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [2:0] r_alu_op;
    logic       r_reg_write;
    logic       r_reg_dst;
    logic       r_mem_to_reg;
    logic       r_halted;
    logic       r_illegal;
    logic       w_fetch_done;

    always_comb begin
        w_state_next = StInit;
        case (r_state)
            StInit:    w_state_next = StFetch;
            StFetch:   w_state_next = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3: w_state_next = StExecR;
                    4'h4:                   w_state_next = StExecI;
                    4'h5, 4'h6:             w_state_next = StMemAddr;
                    4'h7:                   w_state_next = StBranch;
                    4'h8:                   w_state_next = StJump;
                    4'hF:                   w_state_next = StHalt;
`ifdef ILLEGAL_TRAP_EN
                    default:                w_state_next = StTrap;
`else
                    default:                w_state_next = StFetch;
`endif
                endcase
            end
            StExecR:   w_state_next = StWbRi;
            StExecI:   w_state_next = StWbRi;
            StWbRi:    w_state_next = StFetch;
            StMemAddr: w_state_next = (opcode == 4'h5) ? StMemRd :
                                      (opcode == 4'h6) ? StMemWr : StFetch;
            StMemRd:   w_state_next = mem_ready ? StWbMem : StMemRd;
            StWbMem:   w_state_next = StFetch;
            StMemWr:   w_state_next = mem_ready ? StFetch : StMemWr;
            StBranch:  w_state_next = StFetch;
            StJump:    w_state_next = StFetch;
            StHalt:    w_state_next = StHalt;
`ifdef ILLEGAL_TRAP_EN
            StTrap:    w_state_next = StFetch;
`endif
            default:   w_state_next = StInit;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StInit;
            r_pc_load    <= 1'b0;
            r_pc_src     <= 2'd0;
            r_iord       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 2'd0;
            r_alu_op     <= 3'd0;
            r_reg_write  <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc_load    <= 1'b0;
            r_pc_src     <= 2'd0;
            r_iord       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 2'd0;
            r_alu_op     <= 3'd0;
            r_reg_write  <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
            case (w_state_next)
                StFetch: begin
                    r_mem_read  <= 1'b1;
                    r_alu_src_b <= 2'd1;
                end
                StDecode:  r_alu_src_b <= 2'd2;
                StExecR: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_op    <= opcode[2:0];
                end
                StExecI, StMemAddr: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'd2;
                end
                StWbRi: begin
                    r_reg_write <= 1'b1;
                    r_reg_dst   <= (opcode[3:2] == 2'b00);
                end
                StMemRd: begin
                    r_mem_read <= 1'b1;
                    r_iord     <= 1'b1;
                end
                StWbMem: begin
                    r_reg_write  <= 1'b1;
                    r_mem_to_reg <= 1'b1;
                end
                StMemWr: begin
                    r_mem_write <= 1'b1;
                    r_iord      <= 1'b1;
                end
                StBranch: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_op    <= 3'b001;
                    r_pc_src    <= 2'd1;
                end
                StJump: begin
                    r_pc_load <= 1'b1;
                    r_pc_src  <= 2'd2;
                end
                StHalt:    r_halted <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
                StTrap: begin
                    r_illegal <= 1'b1;
                    r_pc_load <= 1'b1;
                    r_pc_src  <= 2'd3;
                end
`endif
                default: ;
            endcase
        end
    end

    assign w_fetch_done = (r_state == StFetch) && mem_ready;
    assign ir_load      = w_fetch_done;
    assign pcsignal     = w_fetch_done || ((r_state == StBranch) && zero) || r_pc_load;
    assign pc_src       = r_pc_src;
    assign trap_vec     = TRAP_VECTOR;
    assign iord         = r_iord;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign alu_src_a    = r_alu_src_a;
    assign alu_src_b    = r_alu_src_b;
    assign alu_op       = r_alu_op;
    assign reg_write    = r_reg_write;
    assign reg_dst      = r_reg_dst;
    assign mem_to_reg   = r_mem_to_reg;
    assign halted       = r_halted;
    assign illegal      = r_illegal;
    assign state_o      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction state-path model with every-cycle output checking.
// Honours ILLEGAL_TRAP_EN to match the DUT build.
module tb_mc_control_fsm;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pcsignal;
    logic [1:0]  pc_src;
    logic [15:0] trap_vec;
    logic        ir_load;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        halted;
    logic        illegal;
    logic [3:0]  state_o;

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcsignal   (pcsignal),
        .pc_src     (pc_src),
        .trap_vec   (trap_vec),
        .ir_load    (ir_load),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt_pc = 0;
    int cnt_ir = 0;
    int cnt_rw = 0;
    int cnt_m2r = 0;

    // Model: current expected state plus the remaining states of the instruction in flight.
    int m_st = 0;
    int m_path[$];

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] expv(input int st, input logic [3:0] op, input logic z,
                                         input logic mr);
        logic pcs, irl, io, mrd, mwr, sa, rw, rd, m2r, hl, il;
        logic [1:0] psrc, sb;
        logic [2:0] aop;
        {pcs, irl, io, mrd, mwr, sa, rw, rd, m2r, hl, il} = '0;
        psrc = 2'd0;
        sb   = 2'd0;
        aop  = 3'd0;
        case (st)
            1:  begin mrd = 1'b1; sb = 2'd1; irl = mr; pcs = mr; end
            2:  sb = 2'd2;
            3:  begin sa = 1'b1; aop = op[2:0]; end
            4:  begin sa = 1'b1; sb = 2'd2; end
            5:  begin rw = 1'b1; rd = (op < 4'd4); end
            6:  begin sa = 1'b1; sb = 2'd2; end
            7:  begin mrd = 1'b1; io = 1'b1; end
            8:  begin rw = 1'b1; m2r = 1'b1; end
            9:  begin mwr = 1'b1; io = 1'b1; end
            10: begin sa = 1'b1; aop = 3'b001; psrc = 2'd1; pcs = z; end
            11: begin pcs = 1'b1; psrc = 2'd2; end
            12: hl = 1'b1;
            13: begin il = 1'b1; pcs = 1'b1; psrc = 2'd3; end
            default: ;
        endcase
        return {pcs, psrc, irl, io, mrd, mwr, sa, sb, aop, rw, rd, m2r, hl, il, 4'(st)};
    endfunction

    task automatic check();
        logic [21:0] act;
        logic [21:0] exp;
        act = {pcsignal, pc_src, ir_load, iord, mem_read, mem_write, alu_src_a, alu_src_b,
               alu_op, reg_write, reg_dst, mem_to_reg, halted, illegal, state_o};
        exp = expv(m_st, opcode, zero, mem_ready);
        lit("outputs", 32'(act), 32'(exp));
        lit("trap_vec", 32'(trap_vec), 32'h0002);
        cnt_pc  += int'(pcsignal);
        cnt_ir  += int'(ir_load);
        cnt_rw  += int'(reg_write);
        cnt_m2r += int'(reg_write & mem_to_reg);
    endtask

    task automatic build_path(input logic [3:0] op);
        m_path.delete();
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin m_path.push_back(3); m_path.push_back(5); end
            4'h4: begin m_path.push_back(4); m_path.push_back(5); end
            4'h5: begin m_path.push_back(6); m_path.push_back(7); m_path.push_back(8); end
            4'h6: begin m_path.push_back(6); m_path.push_back(9); end
            4'h7: m_path.push_back(10);
            4'h8: m_path.push_back(11);
            4'hF: m_path.push_back(12);
`ifdef ILLEGAL_TRAP_EN
            default: m_path.push_back(13);
`else
            default: ;
`endif
        endcase
    endtask

    task automatic advance();
        m_st = (m_path.size() > 0) ? m_path.pop_front() : 1;
    endtask

    task automatic model_step();
        case (m_st)
            0:       m_st = 1;
            1:       if (mem_ready) m_st = 2;
            2:       begin build_path(opcode); advance(); end
            7, 9:    if (mem_ready) advance();
            12:      ;
            default: advance();
        endcase
    endtask

    // Called at a falling edge: drive inputs, check, clock through one rising edge.
    task automatic drive(input logic mr, input logic z, input logic [3:0] op);
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        #1;
        check();
    endtask

    task automatic clk_adv();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(input logic mr, input logic z, input logic [3:0] op);
        drive(mr, z, op);
        clk_adv();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_st  = 0;
        m_path.delete();
        #1;
        lit("rst_state", 32'(state_o), 32'd0);
        lit("rst_mem_write", 32'(mem_write), 32'd0);
        check();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, opcode);
        lit("rst_release_state", 32'(state_o), 32'd1);
    endtask

    int n;
    logic [3:0] r_op;

    initial begin
        reset     = 1'b0;
        opcode    = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #2;
        do_reset();

        // ADD: FETCH, DECODE, EXEC_R, WB_RI.
        cnt_pc = 0;
        lit("add_s0", 32'(state_o), 32'd1);
        step(1'b1, 1'b0, 4'h0);
        lit("add_s1", 32'(state_o), 32'd2);
        step(1'b1, 1'b0, 4'h0);
        lit("add_s2", 32'(state_o), 32'd3);
        lit("add_alu_op", 32'(alu_op), 32'd0);
        step(1'b1, 1'b0, 4'h0);
        lit("add_s3", 32'(state_o), 32'd5);
        lit("add_rw", 32'({reg_write, reg_dst}), 32'd3);
        step(1'b1, 1'b0, 4'h0);
        lit("add_back_fetch", 32'(state_o), 32'd1);
        lit("add_pc_pulses", 32'(cnt_pc), 32'd1);

        // LW with three memory wait cycles: 8 cycles FETCH to FETCH.
        cnt_rw = 0;
        cnt_m2r = 0;
        n = 0;
        step(1'b1, 1'b0, 4'h5);
        n++;
        while (state_o != 4'd1 && n < 20) begin
            drive((state_o == 4'd7) ? (n >= 6) : 1'b1, 1'b0, 4'h5);
            clk_adv();
            n++;
        end
        lit("lw_cycles", 32'(n), 32'd8);
        lit("lw_rw_pulses", 32'(cnt_rw), 32'd1);
        lit("lw_m2r_pulses", 32'(cnt_m2r), 32'd1);

        // BEQ taken then not taken.
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h7);
        drive(1'b1, 1'b1, 4'h7);
        lit("beq_t_pc", 32'({pcsignal, pc_src}), 32'h5);
        clk_adv();
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h7);
        drive(1'b1, 1'b0, 4'h7);
        lit("beq_nt_pc", 32'(pcsignal), 32'd0);
        clk_adv();
        lit("beq_nt_next", 32'(state_o), 32'd1);

        // FETCH stall: no PC/IR pulses until mem_ready, then exactly one.
        cnt_pc = 0;
        cnt_ir = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h8);
        lit("stall_pc", 32'(cnt_pc), 32'd0);
        lit("stall_ir", 32'(cnt_ir), 32'd0);
        step(1'b1, 1'b0, 4'h8);
        lit("stall_pc_one", 32'(cnt_pc), 32'd1);
        lit("stall_ir_one", 32'(cnt_ir), 32'd1);
        step(1'b1, 1'b0, 4'h8);
        step(1'b1, 1'b0, 4'h8);
        lit("jmp_done", 32'(state_o), 32'd1);

        // Illegal opcode 0xA.
        step(1'b1, 1'b0, 4'hA);
        step(1'b1, 1'b0, 4'hA);
`ifdef ILLEGAL_TRAP_EN
        drive(1'b1, 1'b0, 4'hA);
        lit("trap_state", 32'(state_o), 32'd13);
        lit("trap_flags", 32'({illegal, pcsignal, pc_src}), 32'hF);
        lit("trap_vec_val", 32'(trap_vec), 32'h0002);
        clk_adv();
`endif
        lit("illegal_after", 32'(state_o), 32'd1);
        lit("illegal_low", 32'(illegal), 32'd0);

        // SW interrupted by reset during a memory wait.
        step(1'b1, 1'b0, 4'h6);
        step(1'b1, 1'b0, 4'h6);
        step(1'b1, 1'b0, 4'h6);
        drive(1'b0, 1'b0, 4'h6);
        lit("sw_in_memwr", 32'({state_o, mem_write}), 32'h13);
        do_reset();

        // Randomised instruction stream, HALT excluded.
        r_op = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            if (m_st == 1) r_op = 4'($urandom_range(0, 14));
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), r_op);
        end

        // HALT absorbs for 20 cycles.
        while (m_st != 1) step(1'b1, 1'b0, r_op);
        step(1'b1, 1'b0, 4'hF);
        step(1'b1, 1'b0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            lit("halt_hold", 32'({state_o, halted}), 32'h19);
            step($urandom_range(0, 1) == 1, 1'b0, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
